// File: rtl/game_ctrl.sv
// game_ctrl: frame-level sequencer for the dinosaur runner (idle/clear/run/pause/over, BCD score, speed level).
// Optional best-score register and port are built when GAME_CTRL_HISCORE_EN is defined.
module game_ctrl #(
  parameter int FRAMES_PER_POINT = 6,
  parameter int POINTS_PER_LEVEL = 100,
  parameter int MAX_LEVEL        = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fresh,
  input  logic        btn_start,
  input  logic        btn_jump,
  input  logic        btn_pause,
  input  logic        dino_px,
  input  logic        obst_px,
  output logic        game_status,
  output logic        clear,
  output logic        jump_req,
  output logic        game_over,
  output logic [15:0] score,
`ifdef GAME_CTRL_HISCORE_EN
  output logic [15:0] hiscore,
`endif
  output logic [3:0]  level
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_PAUSE, S_OVER} state_t;

  localparam int IN_FRESH = 3;
  localparam int IN_START = 2;
  localparam int IN_JUMP  = 1;
  localparam int IN_PAUSE = 0;

  localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_POINT - 1);
  localparam logic [15:0] POINT_LAST = 16'(POINTS_PER_LEVEL - 1);
  localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);

  state_t      r_state, w_state_next;
  logic [3:0]  r_in_q, r_in_qq;
  logic [7:0]  r_frame;
  logic [15:0] r_points;
  logic        r_hit;
  logic [15:0] r_score;
  logic [3:0]  r_level;
  logic        r_game_status, r_clear, r_jump_req, r_game_over;

  logic        w_tick, w_start_e, w_jump_e, w_pause_e;
  logic        w_in_run, w_enter_clr, w_frame_wrap, w_score_sat;
  logic [15:0] w_score_inc, w_score_next;
  logic [3:0]  w_carry;

  // Second register stage makes every event one cycle late and immune to a held level.
  assign w_tick    = r_in_qq[IN_FRESH] & ~r_in_q[IN_FRESH];
  assign w_start_e = r_in_q[IN_START] & ~r_in_qq[IN_START];
  assign w_jump_e  = r_in_q[IN_JUMP]  & ~r_in_qq[IN_JUMP];
  assign w_pause_e = r_in_q[IN_PAUSE] & ~r_in_qq[IN_PAUSE];

  assign w_in_run     = (r_state == S_RUN);
  assign w_enter_clr  = (w_state_next == S_CLR) && (r_state != S_CLR);
  assign w_frame_wrap = w_in_run && w_tick && (r_frame == FRAME_LAST);
  assign w_score_sat  = (r_score == 16'h9999);

  assign w_carry[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
    logic w_nine;
    assign w_nine = (r_score[4*gi +: 4] == 4'd9);
    assign w_score_inc[4*gi +: 4] = !w_carry[gi] ? r_score[4*gi +: 4] :
                                    (w_nine ? 4'd0 : r_score[4*gi +: 4] + 4'd1);
    if (gi < 3) begin : g_carry
      assign w_carry[gi+1] = w_carry[gi] & w_nine;
    end
  end

  assign w_score_next = (w_frame_wrap && !w_score_sat) ? w_score_inc : r_score;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_e) w_state_next = S_CLR;
      S_CLR:   w_state_next = S_RUN;
      S_RUN: begin
        // A pending hit wins over a pause landing on the same frame tick.
        if (w_tick && r_hit)  w_state_next = S_OVER;
        else if (w_pause_e)   w_state_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_start_e)        w_state_next = S_CLR;
        else if (w_pause_e)   w_state_next = S_RUN;
      end
      S_OVER:  if (w_start_e) w_state_next = S_CLR;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_in_q        <= 4'd0;
      r_in_qq       <= 4'd0;
      r_game_status <= 1'b0;
      r_clear       <= 1'b0;
      r_game_over   <= 1'b0;
      r_jump_req    <= 1'b0;
      r_frame       <= 8'd0;
      r_points      <= 16'd0;
      r_hit         <= 1'b0;
      r_score       <= 16'd0;
      r_level       <= 4'd0;
    end else begin
      r_state       <= w_state_next;
      r_in_q        <= {fresh, btn_start, btn_jump, btn_pause};
      r_in_qq       <= r_in_q;
      r_game_status <= (w_state_next == S_RUN);
      r_clear       <= (w_state_next == S_CLR);
      r_game_over   <= (w_state_next == S_OVER);

      if (w_state_next != S_RUN)    r_jump_req <= 1'b0;
      else if (w_in_run && w_jump_e) r_jump_req <= 1'b1;
      else if (w_tick)              r_jump_req <= 1'b0;

      if (w_enter_clr) begin
        r_frame  <= 8'd0;
        r_points <= 16'd0;
        r_hit    <= 1'b0;
        r_score  <= 16'd0;
        r_level  <= 4'd0;
      end else if (w_in_run) begin
        if (dino_px & obst_px) r_hit <= 1'b1;
        if (w_tick) begin
          r_frame <= (r_frame == FRAME_LAST) ? 8'd0 : r_frame + 8'd1;
          r_score <= w_score_next;
          // Points stop counting once the score display is pinned at 9999.
          if (w_frame_wrap && !w_score_sat) begin
            if (r_points == POINT_LAST) begin
              r_points <= 16'd0;
              if (r_level < LEVEL_MAX) r_level <= r_level + 4'd1;
            end else begin
              r_points <= r_points + 16'd1;
            end
          end
        end
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] r_hiscore;

  // BCD digits compare correctly as a plain binary magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hiscore <= 16'd0;
    end else if (w_in_run && (w_state_next == S_OVER) && (w_score_next > r_hiscore)) begin
      r_hiscore <= w_score_next;
    end
  end

  assign hiscore = r_hiscore;
`endif

  assign game_status = r_game_status;
  assign clear       = r_clear;
  assign jump_req    = r_jump_req;
  assign game_over   = r_game_over;
  assign score       = r_score;
  assign level       = r_level;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: randomized frame/button stimulus against a points-from-frames reference model.
// Instance dut uses default parameters; dut_b runs one frame per point with MAX_LEVEL=1 for saturation checks.
module tb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_fresh, a_btn_start, a_btn_jump, a_btn_pause, a_dino, a_obst;
  logic a_game_status, a_clear, a_jump_req, a_game_over;
  logic [15:0] a_score;
  logic [3:0]  a_level;
  logic b_fresh, b_btn_start, b_btn_jump, b_btn_pause, b_dino, b_obst;
  logic b_game_status, b_clear, b_jump_req, b_game_over;
  logic [15:0] b_score;
  logic [3:0]  b_level;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] a_hiscore, b_hiscore;
`endif

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fresh(a_fresh),
    .btn_start(a_btn_start), .btn_jump(a_btn_jump), .btn_pause(a_btn_pause),
    .dino_px(a_dino), .obst_px(a_obst),
    .game_status(a_game_status), .clear(a_clear), .jump_req(a_jump_req),
    .game_over(a_game_over), .score(a_score),
`ifdef GAME_CTRL_HISCORE_EN
    .hiscore(a_hiscore),
`endif
    .level(a_level)
  );

  game_ctrl #(.FRAMES_PER_POINT(1), .POINTS_PER_LEVEL(100), .MAX_LEVEL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .fresh(b_fresh),
    .btn_start(b_btn_start), .btn_jump(b_btn_jump), .btn_pause(b_btn_pause),
    .dino_px(b_dino), .obst_px(b_obst),
    .game_status(b_game_status), .clear(b_clear), .jump_req(b_jump_req),
    .game_over(b_game_over), .score(b_score),
`ifdef GAME_CTRL_HISCORE_EN
    .hiscore(b_hiscore),
`endif
    .level(b_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_frames = 0;
  int m_frames_b = 0;

  // Reference model: points are whole frames divided by frames-per-point, capped at 9999.
  function automatic int exp_points(input int frames, input int fpp);
    int p;
    p = frames / fpp;
    return (p > 9999) ? 9999 : p;
  endfunction

  function automatic logic [3:0] exp_level(input int pts, input int ppl, input int mx);
    int l;
    l = pts / ppl;
    if (l > mx) l = mx;
    return 4'(l);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick_a(input int gap);
    @(posedge clk); #1 a_fresh = 1'b1;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1 a_fresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) tick_a($urandom_range(0, 2));
  endtask

  task automatic press_a(input int which);
    @(posedge clk); #1;
    case (which)
      0: a_btn_start = 1'b1;
      1: a_btn_jump  = 1'b1;
      default: a_btn_pause = 1'b1;
    endcase
    @(posedge clk); #1;
    a_btn_start = 1'b0; a_btn_jump = 1'b0; a_btn_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    press_a(0);
    m_frames = 0;
  endtask

  task automatic collide_a();
    @(posedge clk); #1 a_fresh = 1'b1; a_dino = 1'b1; a_obst = 1'b1;
    @(posedge clk); #1 a_dino = 1'b0; a_obst = 1'b0;
    @(posedge clk); #1 a_fresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ticks_b(input int n);
    repeat (n) begin
      @(posedge clk); #1 b_fresh = 1'b1;
      @(posedge clk); #1 b_fresh = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_fresh = 0; a_btn_start = 0; a_btn_jump = 0; a_btn_pause = 0; a_dino = 0; a_obst = 0;
    b_fresh = 0; b_btn_start = 0; b_btn_jump = 0; b_btn_pause = 0; b_dino = 0; b_obst = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a_game_status, a_clear, a_jump_req, a_game_over} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {a_game_status, a_clear, a_jump_req, a_game_over});
    end
    n_checks++;
    if ({a_score, a_level} !== 20'h0) begin
      n_fail++; $display("FAIL reset_score_level: got %h/%h expected 0000/0", a_score, a_level);
    end
    n_checks++;
    if ({b_game_status, b_clear, b_jump_req, b_game_over, b_score, b_level} !== 24'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {b_game_status, b_clear, b_jump_req, b_game_over, b_score, b_level});
    end
`ifdef GAME_CTRL_HISCORE_EN
    n_checks++;
    if ({a_hiscore, b_hiscore} !== 32'h0) begin
      n_fail++; $display("FAIL reset_hiscore: got %h/%h expected 0", a_hiscore, b_hiscore);
    end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({a_game_status, a_clear} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected 00", {a_game_status, a_clear});
    end
    $display("test_reset done");
  endtask

  task automatic test_start();
    logic [8:0] clr_seen;
    logic [8:0] run_seen;
    @(posedge clk); #1 a_btn_start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      clr_seen[k] = a_clear;
      run_seen[k] = a_game_status;
      if (k == 6) a_btn_start = 1'b0;
    end
    n_checks++;
    if (clr_seen !== 9'b000000100) begin
      n_fail++; $display("FAIL start_clear_pulse: got %b expected 000000100", clr_seen);
    end
    n_checks++;
    if (run_seen !== 9'b111111000) begin
      n_fail++; $display("FAIL start_game_status: got %b expected 111111000", run_seen);
    end
    n_checks++;
    if ({a_score, a_level} !== 20'h0) begin
      n_fail++; $display("FAIL start_score: got %h/%h expected 0000/0", a_score, a_level);
    end
    m_frames = 0;
    $display("test_start done");
  endtask

  task automatic test_score();
    int rem;
    int n;
    rem = 60;
    while (rem > 0) begin
      n = $urandom_range(1, (rem < 15) ? rem : 15);
      ticks_a(n);
      m_frames += n;
      rem -= n;
      n_checks++;
      if (a_score !== to_bcd(exp_points(m_frames, 6))) begin
        n_fail++; $display("FAIL score_batch: frames=%0d got %h expected %h", m_frames, a_score, to_bcd(exp_points(m_frames, 6)));
      end
    end
    n_checks++;
    if (a_score !== 16'h0010) begin
      n_fail++; $display("FAIL score_60_ticks: got %h expected 0010", a_score);
    end
    press_a(2);
    n_checks++;
    if ({a_game_status, a_game_over} !== 2'b00) begin
      n_fail++; $display("FAIL pause_enter: got %b expected 00", {a_game_status, a_game_over});
    end
    ticks_a(4);
    n_checks++;
    if (a_score !== 16'h0010) begin
      n_fail++; $display("FAIL pause_freeze: got %h expected 0010", a_score);
    end
    press_a(2);
    n_checks++;
    if (a_game_status !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: got %b expected 1", a_game_status);
    end
    $display("test_score done: score=%h", a_score);
  endtask

  task automatic test_jump();
    press_a(1);
    n_checks++;
    if (a_jump_req !== 1'b1) begin
      n_fail++; $display("FAIL jump_set: got %b expected 1", a_jump_req);
    end
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #1;
    n_checks++;
    if (a_jump_req !== 1'b1) begin
      n_fail++; $display("FAIL jump_hold: got %b expected 1", a_jump_req);
    end
    tick_a(0);
    m_frames++;
    n_checks++;
    if (a_jump_req !== 1'b0) begin
      n_fail++; $display("FAIL jump_clear_on_tick: got %b expected 0", a_jump_req);
    end
    press_a(2);
    press_a(1);
    n_checks++;
    if ({a_jump_req, a_game_status} !== 2'b00) begin
      n_fail++; $display("FAIL jump_in_pause: got %b expected 00", {a_jump_req, a_game_status});
    end
    press_a(2);
    n_checks++;
    if ({a_jump_req, a_game_status} !== 2'b01) begin
      n_fail++; $display("FAIL jump_after_resume: got %b expected 01", {a_jump_req, a_game_status});
    end
    $display("test_jump done");
  endtask

  task automatic test_level();
    ticks_a(599 - m_frames);
    m_frames = 599;
    n_checks++;
    if ({a_level, a_score} !== {exp_level(exp_points(m_frames, 6), 100, 7), to_bcd(exp_points(m_frames, 6))}) begin
      n_fail++; $display("FAIL level_before_wrap: got %h/%h expected 0/0099", a_level, a_score);
    end
    tick_a(0);
    m_frames++;
    n_checks++;
    if ({a_level, a_score} !== {4'd1, 16'h0100}) begin
      n_fail++; $display("FAIL level_step: got %h/%h expected 1/0100", a_level, a_score);
    end
    $display("test_level done: level=%0d score=%h", a_level, a_score);
  endtask

  task automatic test_collision();
    int n;
    n = $urandom_range(1, 4);
    ticks_a(n);
    m_frames += n;
    @(posedge clk); #1 a_fresh = 1'b1; a_dino = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_dino = 1'b0; a_obst = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_obst = 1'b0;
    @(posedge clk); #1 a_fresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_frames++;
    n_checks++;
    if ({a_game_over, a_game_status} !== 2'b01) begin
      n_fail++; $display("FAIL no_overlap_no_hit: got %b expected 01", {a_game_over, a_game_status});
    end
    @(posedge clk); #1 a_fresh = 1'b1;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 a_dino = 1'b1; a_obst = 1'b1;
    @(posedge clk); #1 a_dino = 1'b0; a_obst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_game_over, a_game_status} !== 2'b01) begin
      n_fail++; $display("FAIL hit_waits_for_tick: got %b expected 01", {a_game_over, a_game_status});
    end
    @(posedge clk); #1 a_fresh = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (a_game_over !== 1'b0) begin
      n_fail++; $display("FAIL hit_tick_cycle: got %b expected 0", a_game_over);
    end
    @(posedge clk); #1;
    m_frames++;
    n_checks++;
    if ({a_game_over, a_game_status} !== 2'b10) begin
      n_fail++; $display("FAIL hit_over_next_cycle: got %b expected 10", {a_game_over, a_game_status});
    end
    n_checks++;
    if (a_score !== to_bcd(exp_points(m_frames, 6))) begin
      n_fail++; $display("FAIL hit_tick_scores: got %h expected %h", a_score, to_bcd(exp_points(m_frames, 6)));
    end
    ticks_a(7);
    n_checks++;
    if ({a_game_over, a_score} !== {1'b1, to_bcd(exp_points(m_frames, 6))}) begin
      n_fail++; $display("FAIL over_freeze: got %b/%h expected 1/%h", a_game_over, a_score, to_bcd(exp_points(m_frames, 6)));
    end
    $display("test_collision done: score=%h", a_score);
  endtask

  task automatic test_pause_priority();
    start_a();
    n_checks++;
    if ({a_game_over, a_game_status, a_score, a_level} !== {2'b01, 16'h0000, 4'd0}) begin
      n_fail++; $display("FAIL restart_from_over: got %b%b/%h/%h expected 01/0000/0", a_game_over, a_game_status, a_score, a_level);
    end
    ticks_a(3);
    m_frames += 3;
    press_a(0);
    ticks_a(3);
    m_frames += 3;
    n_checks++;
    if ({a_game_status, a_score} !== {1'b1, to_bcd(exp_points(m_frames, 6))}) begin
      n_fail++; $display("FAIL start_ignored_in_run: got %b/%h expected 1/%h", a_game_status, a_score, to_bcd(exp_points(m_frames, 6)));
    end
    @(posedge clk); #1 a_fresh = 1'b1;
    @(posedge clk); #1 a_dino = 1'b1; a_obst = 1'b1;
    @(posedge clk); #1 a_dino = 1'b0; a_obst = 1'b0;
    @(posedge clk); #1 a_fresh = 1'b0; a_btn_pause = 1'b1;
    @(posedge clk); #1 a_btn_pause = 1'b0;
    @(posedge clk); #1;
    m_frames++;
    n_checks++;
    if ({a_game_over, a_game_status} !== 2'b10) begin
      n_fail++; $display("FAIL hit_beats_pause: got %b expected 10", {a_game_over, a_game_status});
    end
    press_a(2);
    n_checks++;
    if ({a_game_over, a_game_status, a_score} !== {2'b10, to_bcd(exp_points(m_frames, 6))}) begin
      n_fail++; $display("FAIL pause_in_over: got %b%b/%h expected 10/%h", a_game_over, a_game_status, a_score, to_bcd(exp_points(m_frames, 6)));
    end
    $display("test_pause_priority done");
  endtask

`ifdef GAME_CTRL_HISCORE_EN
  task automatic test_hiscore();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_a();
    ticks_a(252);
    m_frames = 252;
    n_checks++;
    if (a_score !== 16'h0042) begin
      n_fail++; $display("FAIL hiscore_pre: got %h expected 0042", a_score);
    end
    collide_a();
    n_checks++;
    if ({a_game_over, a_hiscore} !== {1'b1, 16'h0042}) begin
      n_fail++; $display("FAIL hiscore_set: got %b/%h expected 1/0042", a_game_over, a_hiscore);
    end
    start_a();
    n_checks++;
    if ({a_score, a_hiscore} !== {16'h0000, 16'h0042}) begin
      n_fail++; $display("FAIL hiscore_survives_clear: got %h/%h expected 0000/0042", a_score, a_hiscore);
    end
    ticks_a(180);
    collide_a();
    n_checks++;
    if ({a_game_over, a_score, a_hiscore} !== {1'b1, 16'h0030, 16'h0042}) begin
      n_fail++; $display("FAIL hiscore_kept: got %b/%h/%h expected 1/0030/0042", a_game_over, a_score, a_hiscore);
    end
    $display("test_hiscore done: hiscore=%h", a_hiscore);
  endtask
`endif

  task automatic test_saturation();
    int n;
    @(posedge clk); #1 b_btn_start = 1'b1;
    @(posedge clk); #1 b_btn_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_frames_b = 0;
    n_checks++;
    if ({b_game_status, b_score} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL b_start: got %b/%h expected 1/0000", b_game_status, b_score);
    end
    while (m_frames_b < 99) begin
      n = $urandom_range(1, 99 - m_frames_b);
      ticks_b(n);
      m_frames_b += n;
    end
    n_checks++;
    if ({b_level, b_score} !== {exp_level(exp_points(m_frames_b, 1), 100, 1), to_bcd(exp_points(m_frames_b, 1))}) begin
      n_fail++; $display("FAIL b_99_points: got %h/%h expected 0/0099", b_level, b_score);
    end
    ticks_b(101);
    m_frames_b += 101;
    n_checks++;
    if ({b_level, b_score} !== {4'd1, 16'h0200}) begin
      n_fail++; $display("FAIL b_level_capped: got %h/%h expected 1/0200", b_level, b_score);
    end
    while (m_frames_b < 9998) begin
      n = $urandom_range(500, 1500);
      if (n > 9998 - m_frames_b) n = 9998 - m_frames_b;
      ticks_b(n);
      m_frames_b += n;
      n_checks++;
      if ({b_level, b_score} !== {exp_level(exp_points(m_frames_b, 1), 100, 1), to_bcd(exp_points(m_frames_b, 1))}) begin
        n_fail++; $display("FAIL b_batch: frames=%0d got %h/%h expected %h/%h", m_frames_b, b_level, b_score,
                           exp_level(exp_points(m_frames_b, 1), 100, 1), to_bcd(exp_points(m_frames_b, 1)));
      end
    end
    n_checks++;
    if (b_score !== 16'h9998) begin
      n_fail++; $display("FAIL b_9998: got %h expected 9998", b_score);
    end
    ticks_b(12);
    n_checks++;
    if ({b_level, b_score} !== {4'd1, 16'h9999}) begin
      n_fail++; $display("FAIL b_saturate: got %h/%h expected 1/9999", b_level, b_score);
    end
    ticks_b(5);
    n_checks++;
    if (b_score !== 16'h9999) begin
      n_fail++; $display("FAIL b_hold_9999: got %h expected 9999", b_score);
    end
    $display("test_saturation done: score=%h level=%0d", b_score, b_level);
  endtask

  task automatic test_reset_midrun();
    logic [5:0] seen;
    start_a();
    ticks_a(7);
    m_frames += 7;
    press_a(1);
    n_checks++;
    if ({a_jump_req, a_score} !== {1'b1, to_bcd(exp_points(m_frames, 6))}) begin
      n_fail++; $display("FAIL midrun_precondition: got %b/%h expected 1/%h", a_jump_req, a_score, to_bcd(exp_points(m_frames, 6)));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_game_status, a_clear, a_jump_req, a_game_over, a_score, a_level} !== 24'h0) begin
      n_fail++; $display("FAIL midrun_async_reset: got %h expected 0",
                         {a_game_status, a_clear, a_jump_req, a_game_over, a_score, a_level});
    end
`ifdef GAME_CTRL_HISCORE_EN
    n_checks++;
    if (a_hiscore !== 16'h0) begin
      n_fail++; $display("FAIL midrun_hiscore_reset: got %h expected 0000", a_hiscore);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen[k] = a_clear | a_game_status;
    end
    n_checks++;
    if (seen !== 6'b0) begin
      n_fail++; $display("FAIL midrun_no_clear_pulse: got %b expected 000000", seen);
    end
    $display("test_reset_midrun done");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_score();
    test_jump();
    test_level();
    test_collision();
    test_pause_priority();
`ifdef GAME_CTRL_HISCORE_EN
    test_hiscore();
`endif
    test_saturation();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
